// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ
// writeback requesters, with a registered write stage and a pending scoreboard.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [5*NUM_REQ-1:0]      req_reg,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      reserve_valid,
  input  logic [4:0]                reserve_reg,
  input  logic [4:0]                read_reg_a,
  input  logic [4:0]                read_reg_b,
  output logic                      pending_a,
  output logic                      pending_b,
  output logic                      ctrl_writeEnable,
  output logic [4:0]                ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;
  logic [PTR_W-1:0]  idx_hi;
  logic [PTR_W-1:0]  idx_lo;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found_hi;
  logic              vld_p0;
  logic [4:0]        reg_p0;
  logic [DATA_W-1:0] data_p0;
  logic [31:0]       pending;
  logic [31:0]       pending_nxt;
  logic              we_p1;
  logic [4:0]        reg_p1;
  logic [DATA_W-1:0] data_p1;

  // Stage p0: pick the lowest valid index at or above rr_ptr, else wrap to the lowest valid index
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        idx_lo = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          idx_hi   = PTR_W'(i);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
    vld_p0  = (|req_valid) & ~reset;
  end

  always_comb begin
    req_ready = '0;
    reg_p0    = '0;
    data_p0   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        req_ready[i] = vld_p0;
        reg_p0       = req_reg[5*i +: 5];
        data_p0      = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (vld_p0) begin
      rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // A same-cycle reserve of the register being retired wins: it names a new producer
  always_comb begin
    pending_nxt = pending;
    if (vld_p0) begin
      pending_nxt[reg_p0] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != 5'd0)) begin
      pending_nxt[reserve_reg] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Stage p1: registered regfile write controls and scoreboard state
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr  <= '0;
      pending <= '0;
      we_p1   <= 1'b0;
      reg_p1  <= '0;
      data_p1 <= '0;
    end else begin
      rr_ptr  <= rr_ptr_nxt;
      pending <= pending_nxt;
      we_p1   <= vld_p0 && (reg_p0 != 5'd0);
      if (vld_p0) begin
        reg_p1  <= reg_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign ctrl_writeEnable = we_p1;
  assign ctrl_writeReg    = reg_p1;
  assign data_writeReg    = data_p1;
  assign pending_a        = pending[read_reg_a];
  assign pending_b        = pending[read_reg_b];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued at
// grant time and compared against the registered write port one cycle later.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [5*NUM_REQ-1:0]      req_reg;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      reserve_valid;
  logic [4:0]                reserve_reg;
  logic [4:0]                read_reg_a;
  logic [4:0]                read_reg_b;
  logic                      pending_a;
  logic                      pending_b;
  logic                      ctrl_writeEnable;
  logic [4:0]                ctrl_writeReg;
  logic [DATA_W-1:0]         data_writeReg;

  typedef struct packed {
    logic              we;
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .reserve_valid    (reserve_valid),
    .reserve_reg      (reserve_reg),
    .read_reg_a       (read_reg_a),
    .read_reg_b       (read_reg_b),
    .pending_a        (pending_a),
    .pending_b        (pending_b),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [DATA_W-1:0] d);
    req_reg[5*i +: 5]           = r;
    req_data[DATA_W*i +: DATA_W] = d;
  endtask

  // Called just after a falling edge with inputs already driven for this cycle
  task automatic cycle(input string tag, input logic [2:0] exp_rdy, input logic exp_hs,
                       input logic [4:0] exp_reg, input logic [DATA_W-1:0] exp_data);
    wr_t e;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    if (exp_hs) sb.push_back('{we: (exp_reg != 5'd0), r: exp_reg, d: exp_data});
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_we"},   64'(ctrl_writeEnable), 64'(e.we));
      chk({tag, "_reg"},  64'(ctrl_writeReg),    64'(e.r));
      chk({tag, "_data"}, 64'(data_writeReg),    64'(e.d));
    end else begin
      chk({tag, "_we_idle"}, 64'(ctrl_writeEnable), 64'(1'b0));
    end
    @(negedge clock);
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 3'b111;
    req_reg       = '0;
    req_data      = '0;
    reserve_valid = 1'b0;
    reserve_reg   = 5'd0;
    read_reg_a    = 5'd1;
    read_reg_b    = 5'd0;
    set_req(0, 5'd5, 32'h1000_0005);
    set_req(1, 5'd6, 32'h1000_0006);
    set_req(2, 5'd7, 32'h1000_0007);

    // Reset held two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_ready", 64'(req_ready), 64'(3'b000));
      chk("rst_we",    64'(ctrl_writeEnable), 64'(1'b0));
      chk("rst_reg",   64'(ctrl_writeReg), 64'(5'd0));
      chk("rst_data",  64'(data_writeReg), 64'(32'h0));
      chk("rst_pend",  64'(pending_a), 64'(1'b0));
    end
    reset = 1'b0;

    // Round robin across three continuously valid requesters
    cycle("rr0", 3'b001, 1'b1, 5'd5, 32'h1000_0005);
    cycle("rr1", 3'b010, 1'b1, 5'd6, 32'h1000_0006);
    cycle("rr2", 3'b100, 1'b1, 5'd7, 32'h1000_0007);
    cycle("rr3", 3'b001, 1'b1, 5'd5, 32'h1000_0005);
    req_valid = 3'b000;
    cycle("idle", 3'b000, 1'b0, 5'd0, 32'h0);

    // Write to $0 completes the handshake without enabling the write
    req_valid = 3'b100;
    set_req(2, 5'd0, 32'hDEAD_BEEF);
    cycle("zero", 3'b100, 1'b1, 5'd0, 32'hDEAD_BEEF);
    req_valid = 3'b000;
    cycle("zero_idle", 3'b000, 1'b0, 5'd0, 32'h0);

    // Reserve then retire reg 9
    reserve_valid = 1'b1;
    reserve_reg   = 5'd9;
    read_reg_a    = 5'd9;
    chk("res9_before", 64'(pending_a), 64'(1'b0));
    cycle("res9", 3'b000, 1'b0, 5'd0, 32'h0);
    reserve_valid = 1'b0;
    chk("res9_set", 64'(pending_a), 64'(1'b1));
    req_valid = 3'b010;
    set_req(1, 5'd9, 32'h0000_0099);
    cycle("wr9", 3'b010, 1'b1, 5'd9, 32'h0000_0099);
    req_valid = 3'b000;
    chk("wr9_clear", 64'(pending_a), 64'(1'b0));

    // Reserve and retire of the same register in one cycle: set wins
    reserve_valid = 1'b1;
    reserve_reg   = 5'd12;
    read_reg_a    = 5'd12;
    cycle("res12", 3'b000, 1'b0, 5'd0, 32'h0);
    req_valid = 3'b001;
    set_req(0, 5'd12, 32'h0000_000C);
    cycle("res_wr12", 3'b001, 1'b1, 5'd12, 32'h0000_000C);
    chk("set_wins", 64'(pending_a), 64'(1'b1));

    // Reserve 13 while retiring 12: both apply
    reserve_reg = 5'd13;
    read_reg_b  = 5'd13;
    cycle("res13_wr12", 3'b001, 1'b1, 5'd12, 32'h0000_000C);
    req_valid = 3'b000;
    chk("clr12", 64'(pending_a), 64'(1'b0));
    chk("set13", 64'(pending_b), 64'(1'b1));

    // Reserving $0 never marks it pending
    reserve_reg = 5'd0;
    read_reg_b  = 5'd0;
    cycle("res0", 3'b000, 1'b0, 5'd0, 32'h0);
    chk("res0_pend", 64'(pending_b), 64'(1'b0));

    // Reset while requester 1 is granted and reg 3 is pending
    reserve_reg = 5'd3;
    read_reg_a  = 5'd3;
    cycle("res3", 3'b000, 1'b0, 5'd0, 32'h0);
    reserve_valid = 1'b0;
    chk("res3_set", 64'(pending_a), 64'(1'b1));
    req_valid = 3'b010;
    set_req(1, 5'd4, 32'h0000_0044);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(3'b000));
    @(posedge clock);
    #1;
    chk("midrst_we",   64'(ctrl_writeEnable), 64'(1'b0));
    chk("midrst_reg",  64'(ctrl_writeReg), 64'(5'd0));
    chk("midrst_data", 64'(data_writeReg), 64'(32'h0));
    @(negedge clock);
    chk("midrst_pend3", 64'(pending_a), 64'(1'b0));
    reset = 1'b0;

    // rr_ptr restarted at 0: requester 0 wins over 2, then 2 follows
    req_valid = 3'b101;
    set_req(0, 5'd20, 32'h0000_0020);
    set_req(2, 5'd21, 32'h0000_0021);
    cycle("post0", 3'b001, 1'b1, 5'd20, 32'h0000_0020);
    cycle("post1", 3'b100, 1'b1, 5'd21, 32'h0000_0021);
    req_valid = 3'b000;
    cycle("post_idle", 3'b000, 1'b0, 5'd0, 32'h0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
